counter_mod_k_ctrl: RTL and testbench
=====================================

# counter_mod_k_ctrl

Parametrised modulo-k counter for timebase and prescaler duties. Supports count enable, synchronous clear and load, a shadowed modulus that changes only at a wrap boundary, a one-cycle wrap pulse and a wrap-event counter. Optional up/down counting is a compile-time feature. It sits between the register interface, which supplies the modulus, load value and controls, and downstream blocks that consume the count or the wrap strobe.

## Interface
Parameters:
- N, 8, count/modulus width
- M, 16, wrap-event counter width
- K_RESET, 10, active modulus after reset (0 < K_RESET < 2^N)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_en  in  1  count enable
- i_clear  in  1  synchronous clear
- i_load  in  1  synchronous load strobe
- i_load_val  in  N  value for load
- i_k  in  N  new modulus (0 means 2^N)
- i_k_wr  in  1  stage i_k into the shadow register
- i_dir  in  1  0 = up, 1 = down (present only with COUNTER_MOD_K_UPDOWN_EN)
- o_count  out  N  current count
- o_wrap  out  1  single-cycle wrap strobe
- o_wraps  out  M  number of wraps, modulo 2^M
- o_k_pending  out  1  staged modulus not yet active

## Operation
- Internal registers: count, active k (k_act), staged k (k_stg), pending flag, wrap flag, wrap counter.
- Effective modulus is K = (k_act == 0) ? 2^N : k_act. All arithmetic is N bits wide with no overflow beyond N.
- Per-cycle priority is clear > load > count.
  - Clear: count = 0. If pending, k_act = k_stg. o_wrap = 0.
  - Load: count = min(i_load_val, K-1). o_wrap = 0. k_act is unchanged.
  - Count (i_en=1), up: if count == K-1 then count = 0 (wrap), else count + 1.
  - Count (i_en=1), down: if count == 0 then count = K-1 (wrap), else count - 1.
  - i_en=0: hold everything. o_wrap = 0.
- On a wrap:
  - o_wrap = 1 for exactly one cycle.
  - o_wraps increments and rolls over from 2^M-1 to 0.
  - If pending, k_act = k_stg and pending clears. For down counting the reload value uses the new modulus.
- i_k_wr:
  - k_stg = i_k and pending = 1.
  - A later write before the boundary overwrites k_stg; the last value wins.
  - If i_k_wr coincides with a wrap or clear, i_k is applied directly to k_act and pending stays 0.
- K = 1: count stays 0, and o_wrap fires on every enabled cycle.
- Load during a pending modulus change: the value is clamped against the old K.
- Once K has been applied at a boundary, count is always < K.

## Timing
- All outputs are registered. Zero combinational paths exist from inputs to outputs.
- Reset values: o_count = 0, o_wrap = 0, o_wraps = 0, o_k_pending = 0, k_act = K_RESET, k_stg = K_RESET.
- Reset asserted mid-count returns every register to its reset value immediately, without waiting for a clock edge.
- Control latency is one cycle: an input sampled at edge t is visible on the outputs after edge t.
- Up counting: o_wrap is high in the same cycle that o_count shows 0 after a wrap.
- Down counting: o_wrap is high in the same cycle that o_count shows K-1.
- o_k_pending rises the cycle after i_k_wr. It falls the cycle after the boundary that applied the staged value.
- The wrap period is exactly K enabled cycles.

## Configuration
- Macro: COUNTER_MOD_K_UPDOWN_EN.
- Defined: the i_dir port exists and down counting behaves as described above.
- Undefined: the i_dir port is absent and the block counts up only. The down-count logic is not synthesised.
- All other behaviour is identical in both builds.

## Structure
- Package counter_pkg holds:
  - a typedef enum for direction: DIR_UP = 0, DIR_DOWN = 1.
  - a function computing the effective modulus (0 maps to 2^N) and the clamp helper.
- One sub-module, counter_mod_k_shadow, holds k_stg, k_act and the pending flag. Its inputs are i_k, i_k_wr and the boundary strobe; its output is k_act.
- The top level holds the count datapath, the wrap flag and the wrap counter.

## Test plan
- Reset, then 25 enabled cycles with K_RESET = 10 (up) -> count sequence 0..9,0..9,0..4. o_wrap high at cycles 10 and 20. o_wraps = 2.
- Write i_k = 4 at count 3 (K = 10) -> o_k_pending = 1 until the wrap after count 9. Then the sequence is 0..3 repeating and o_k_pending = 0.
- i_load = 1, i_load_val = 15 with K = 10 -> count = 9. On the next enabled cycle count = 0 and o_wrap = 1.
- i_clear and i_load together with i_en = 1 -> count = 0 and o_wrap = 0. A pending i_k = 6 becomes active.
- i_k = 0, N = 8 -> wrap after count 255. i_k = 1 -> o_wrap high on every enabled cycle and count stays 0.
- With COUNTER_MOD_K_UPDOWN_EN, i_dir = 1 and K = 5 -> sequence 0,4,3,2,1,0,4. o_wrap is high whenever count shows 4. Async reset asserted mid-sequence returns all outputs to 0 immediately.

Source files
------------

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared types and helpers for the modulo-k counter.
//   dir_e       : count direction (DIR_UP / DIR_DOWN)
//   eff_mod     : effective modulus, where a programmed 0 stands for 2^n
//   clamp_to    : limits a value to an upper bound (used for load clamping)
// Helpers work on 32-bit values, so counter widths up to 32 bits are supported.
// ---------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Effective modulus; one extra bit so that 2^n is representable.
    function automatic logic [32:0] eff_mod(input logic [31:0] k, input int unsigned n);
        logic [32:0] res;
        if (k == 32'd0) begin
            res = 33'd1 << n;
        end else begin
            res = {1'b0, k};
        end
        return res;
    endfunction

    // Returns v limited to at most lim.
    function automatic logic [31:0] clamp_to(input logic [31:0] v, input logic [31:0] lim);
        logic [31:0] res;
        if (v > lim) begin
            res = lim;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/counter_mod_k_shadow.sv
// ---------------------------------------------------------------------------
// counter_mod_k_shadow
// Holds the staged modulus (k_stg), the active modulus (k_act) and the
// pending flag. A staged value only becomes active at a boundary (wrap or
// clear); a write that coincides with a boundary goes straight to k_act.
// Optional macro: COUNTER_MOD_K_UPDOWN_EN adds o_k_next, needed by the
// down-count reload.
// Ports:
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_k, i_k_wr     : new modulus and its write strobe
//   i_boundary      : a wrap or clear happens at the coming edge
//   o_k_act         : active modulus (registered)
//   o_pending       : staged modulus waiting for a boundary (registered)
//   o_k_next        : modulus that will be active after this edge if a
//                     boundary occurs (only with COUNTER_MOD_K_UPDOWN_EN)
// ---------------------------------------------------------------------------
module counter_mod_k_shadow
    import counter_pkg::*;
#(
    parameter int N       = 8,
    parameter int K_RESET = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_k,
    input  logic         i_k_wr,
    input  logic         i_boundary,
`ifdef COUNTER_MOD_K_UPDOWN_EN
    output logic [N-1:0] o_k_next,
`endif
    output logic [N-1:0] o_k_act,
    output logic         o_pending
);

    logic [N-1:0] k_act_q, k_act_d;
    logic [N-1:0] k_stg_q, k_stg_d;
    logic         pending_q, pending_d;
    logic [N-1:0] k_apply_s;

    // Value k_act takes if a boundary fires now: a same-cycle write wins.
    always_comb begin
        k_apply_s = k_act_q;
        if (i_k_wr) begin
            k_apply_s = i_k;
        end else if (pending_q) begin
            k_apply_s = k_stg_q;
        end else begin
            k_apply_s = k_act_q;
        end
    end

    // Next-state for the shadow registers.
    always_comb begin
        k_act_d   = k_act_q;
        k_stg_d   = k_stg_q;
        pending_d = pending_q;
        if (i_boundary) begin
            k_act_d   = k_apply_s;
            pending_d = 1'b0;
            if (i_k_wr) begin
                k_stg_d = i_k;
            end else begin
                k_stg_d = k_stg_q;
            end
        end else if (i_k_wr) begin
            k_stg_d   = i_k;
            pending_d = 1'b1;
        end else begin
            k_stg_d   = k_stg_q;
            pending_d = pending_q;
        end
    end

    // Shadow register bank.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            k_act_q   <= N'(K_RESET);
            k_stg_q   <= N'(K_RESET);
            pending_q <= 1'b0;
        end else begin
            k_act_q   <= k_act_d;
            k_stg_q   <= k_stg_d;
            pending_q <= pending_d;
        end
    end

    assign o_k_act   = k_act_q;
    assign o_pending = pending_q;
`ifdef COUNTER_MOD_K_UPDOWN_EN
    assign o_k_next  = k_apply_s;
`endif

endmodule

// File: rtl/counter_mod_k_ctrl.sv
// ---------------------------------------------------------------------------
// counter_mod_k_ctrl
// Modulo-k counter with enable, synchronous clear/load, shadowed modulus,
// single-cycle wrap strobe and a wrap-event counter. All outputs registered.
// Optional macro: COUNTER_MOD_K_UPDOWN_EN adds i_dir and down counting;
// without it the block counts up only.
// Parameters: N (count width), M (wrap counter width), K_RESET (modulus
// after reset, 0 < K_RESET < 2^N).
// Ports:
//   i_clk, i_reset      : clock, asynchronous active-high reset
//   i_en                : count enable
//   i_clear, i_load     : synchronous clear / load (clear > load > count)
//   i_load_val          : load value, clamped to K-1
//   i_k, i_k_wr         : new modulus (0 means 2^N) and staging strobe
//   i_dir               : 0 up, 1 down (COUNTER_MOD_K_UPDOWN_EN only)
//   o_count             : current count
//   o_wrap              : one-cycle wrap strobe
//   o_wraps             : wrap count modulo 2^M
//   o_k_pending         : staged modulus not yet active
// ---------------------------------------------------------------------------
module counter_mod_k_ctrl
    import counter_pkg::*;
#(
    parameter int N       = 8,
    parameter int M       = 16,
    parameter int K_RESET = 10
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    input  logic [N-1:0] i_k,
    input  logic         i_k_wr,
`ifdef COUNTER_MOD_K_UPDOWN_EN
    input  logic         i_dir,
`endif
    output logic [N-1:0] o_count,
    output logic         o_wrap,
    output logic [M-1:0] o_wraps,
    output logic         o_k_pending
);

    logic [N-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic [M-1:0] wraps_q, wraps_d;
    logic         boundary_s;
    logic [N-1:0] k_act_s;
    logic [N-1:0] kmax_s;
    logic         pending_s;
`ifdef COUNTER_MOD_K_UPDOWN_EN
    logic [N-1:0] k_next_s;
    logic [N-1:0] knext_max_s;
    dir_e         dir_s;
`endif

    counter_mod_k_shadow #(
        .N       (N),
        .K_RESET (K_RESET)
    ) u_shadow (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_k        (i_k),
        .i_k_wr     (i_k_wr),
        .i_boundary (boundary_s),
`ifdef COUNTER_MOD_K_UPDOWN_EN
        .o_k_next   (k_next_s),
`endif
        .o_k_act    (k_act_s),
        .o_pending  (pending_s)
    );

    // Largest legal count for the active and (for down reload) the next modulus.
    always_comb begin
        kmax_s      = N'(eff_mod(32'(k_act_s), N) - 33'd1);
`ifdef COUNTER_MOD_K_UPDOWN_EN
        knext_max_s = N'(eff_mod(32'(k_next_s), N) - 33'd1);
        dir_s       = dir_e'(i_dir);
`endif
    end

    // Count datapath, wrap detection and wrap-event counter.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        wraps_d    = wraps_q;
        boundary_s = 1'b0;
        if (i_clear) begin
            count_d    = {N{1'b0}};
            boundary_s = 1'b1;
        end else if (i_load) begin
            // Clamped against the currently active modulus, even if a new one is staged.
            count_d = N'(clamp_to(32'(i_load_val), 32'(kmax_s)));
        end else if (i_en) begin
`ifdef COUNTER_MOD_K_UPDOWN_EN
            if (dir_s == DIR_DOWN) begin
                if (count_q == {N{1'b0}}) begin
                    // Reload from the modulus that becomes active at this wrap.
                    count_d    = knext_max_s;
                    wrap_d     = 1'b1;
                    boundary_s = 1'b1;
                end else begin
                    count_d = count_q - {{(N-1){1'b0}}, 1'b1};
                end
            end else begin
                if (count_q == kmax_s) begin
                    count_d    = {N{1'b0}};
                    wrap_d     = 1'b1;
                    boundary_s = 1'b1;
                end else begin
                    count_d = count_q + {{(N-1){1'b0}}, 1'b1};
                end
            end
`else
            if (count_q == kmax_s) begin
                count_d    = {N{1'b0}};
                wrap_d     = 1'b1;
                boundary_s = 1'b1;
            end else begin
                count_d = count_q + {{(N-1){1'b0}}, 1'b1};
            end
`endif
        end else begin
            count_d = count_q;
        end

        if (wrap_d) begin
            wraps_d = wraps_q + {{(M-1){1'b0}}, 1'b1};
        end else begin
            wraps_d = wraps_q;
        end
    end

    // Output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= {N{1'b0}};
            wrap_q  <= 1'b0;
            wraps_q <= {M{1'b0}};
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            wraps_q <= wraps_d;
        end
    end

    assign o_count     = count_q;
    assign o_wrap      = wrap_q;
    assign o_wraps     = wraps_q;
    assign o_k_pending = pending_s;

endmodule

// File: tb/tb_counter_mod_k_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_mod_k_ctrl
// Self-checking bench: directed sequences with literal expectations plus a
// randomized run, all outputs compared every cycle against an integer model.
// Build with COUNTER_MOD_K_UPDOWN_EN to include the down-count scenarios.
// ---------------------------------------------------------------------------
module tb_counter_mod_k_ctrl;

    localparam int N = 8;
    localparam int M = 4;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_en, i_clear, i_load, i_k_wr, i_dir;
    logic [N-1:0] i_load_val, i_k;
    logic [N-1:0] o_count;
    logic         o_wrap;
    logic [M-1:0] o_wraps;
    logic         o_k_pending;

    int checks = 0;
    int fails  = 0;
    bit run    = 1'b0;

    // Behavioural model state
    int m_cnt, m_kact, m_kstg, m_pend, m_wrap, m_wraps;
    int m_kold;
    bit m_bnd, m_wr, m_down;

    counter_mod_k_ctrl #(.N(N), .M(M), .K_RESET(10)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_en        (i_en),
        .i_clear     (i_clear),
        .i_load      (i_load),
        .i_load_val  (i_load_val),
        .i_k         (i_k),
        .i_k_wr      (i_k_wr),
`ifdef COUNTER_MOD_K_UPDOWN_EN
        .i_dir       (i_dir),
`endif
        .o_count     (o_count),
        .o_wrap      (o_wrap),
        .o_wraps     (o_wraps),
        .o_k_pending (o_k_pending)
    );

    always #5 i_clk = ~i_clk;

    function automatic int eff(input int k);
        return (k == 0) ? (1 << N) : k;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one update per clock edge, straight from the counter rules.
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_cnt = 0; m_kact = 10; m_kstg = 10; m_pend = 0; m_wrap = 0; m_wraps = 0;
        end else begin
            m_kold = eff(m_kact);
            m_bnd  = 1'b0;
            m_wr   = 1'b0;
`ifdef COUNTER_MOD_K_UPDOWN_EN
            m_down = i_dir;
`else
            m_down = 1'b0;
`endif
            if (i_clear) begin
                m_cnt = 0;
                m_bnd = 1'b1;
            end else if (i_load) begin
                m_cnt = (int'(i_load_val) > m_kold - 1) ? m_kold - 1 : int'(i_load_val);
            end else if (i_en) begin
                if (!m_down) begin
                    if (m_cnt == m_kold - 1) begin m_cnt = 0; m_wr = 1'b1; m_bnd = 1'b1; end
                    else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt == 0) begin m_wr = 1'b1; m_bnd = 1'b1; end
                    else m_cnt = m_cnt - 1;
                end
            end
            if (m_bnd) begin
                if (i_k_wr) begin m_kact = int'(i_k); m_kstg = int'(i_k); m_pend = 0; end
                else if (m_pend != 0) begin m_kact = m_kstg; m_pend = 0; end
            end else if (i_k_wr) begin
                m_kstg = int'(i_k);
                m_pend = 1;
            end
            if (m_wr && m_down) m_cnt = eff(m_kact) - 1;
            m_wrap = m_wr ? 1 : 0;
            if (m_wr) m_wraps = (m_wraps + 1) % (1 << M);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge i_clk) begin
        if (run && !i_reset) begin
            cmp("mdl_count", 32'(o_count), 32'(m_cnt));
            cmp("mdl_wrap", 32'(o_wrap), 32'(m_wrap));
            cmp("mdl_wraps", 32'(o_wraps), 32'(m_wraps));
            cmp("mdl_pending", 32'(o_k_pending), 32'(m_pend));
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_k(input logic [N-1:0] k);
        i_en = 1'b0; i_k = k; i_k_wr = 1'b1; i_clear = 1'b1;
        tick();
        i_k_wr = 1'b0; i_clear = 1'b0;
    endtask

    int down_exp [6] = '{4, 3, 2, 1, 0, 4};

    initial begin
        i_reset = 1'b1; i_en = 1'b0; i_clear = 1'b0; i_load = 1'b0; i_k_wr = 1'b0;
        i_dir = 1'b0; i_load_val = '0; i_k = '0;
        #12 i_reset = 1'b0;
        run = 1'b1;
        #1;
        cmp("rst_count", 32'(o_count), 32'd0);
        cmp("rst_wrap", 32'(o_wrap), 32'd0);
        cmp("rst_wraps", 32'(o_wraps), 32'd0);
        cmp("rst_pending", 32'(o_k_pending), 32'd0);

        // 25 enabled cycles with K = 10
        i_en = 1'b1;
        for (int j = 1; j <= 25; j++) begin
            tick();
            cmp("k10_count", 32'(o_count), 32'(j % 10));
            cmp("k10_wrap", 32'(o_wrap), 32'((j % 10) == 0));
        end
        cmp("k10_wraps", 32'(o_wraps), 32'd2);

        // Stage K = 4 at count 3; takes effect at the wrap after 9
        i_en = 1'b0; i_clear = 1'b1; tick(); i_clear = 1'b0;
        i_en = 1'b1;
        for (int j = 0; j < 3; j++) tick();
        cmp("pre_stage_count", 32'(o_count), 32'd3);
        i_k = 8'd4; i_k_wr = 1'b1; tick(); i_k_wr = 1'b0;
        cmp("stage_pending", 32'(o_k_pending), 32'd1);
        for (int j = 5; j <= 9; j++) begin
            tick();
            cmp("stage_count", 32'(o_count), 32'(j));
            cmp("stage_pend_hold", 32'(o_k_pending), 32'd1);
        end
        tick();
        cmp("k4_apply_count", 32'(o_count), 32'd0);
        cmp("k4_apply_wrap", 32'(o_wrap), 32'd1);
        cmp("k4_apply_pend", 32'(o_k_pending), 32'd0);
        for (int j = 1; j <= 8; j++) begin
            tick();
            cmp("k4_count", 32'(o_count), 32'(j % 4));
            cmp("k4_wrap", 32'(o_wrap), 32'((j % 4) == 0));
        end

        // Load clamp with K = 10
        apply_k(8'd10);
        cmp("k10_direct_pend", 32'(o_k_pending), 32'd0);
        i_load = 1'b1; i_load_val = 8'd15; i_en = 1'b1; tick(); i_load = 1'b0;
        cmp("load_clamp_count", 32'(o_count), 32'd9);
        cmp("load_clamp_wrap", 32'(o_wrap), 32'd0);
        tick();
        cmp("load_next_count", 32'(o_count), 32'd0);
        cmp("load_next_wrap", 32'(o_wrap), 32'd1);

        // Clear beats load; pending K = 6 applied by the clear
        i_en = 1'b0; i_k = 8'd6; i_k_wr = 1'b1; tick(); i_k_wr = 1'b0;
        cmp("k6_pending", 32'(o_k_pending), 32'd1);
        i_clear = 1'b1; i_load = 1'b1; i_load_val = 8'd3; i_en = 1'b1; tick();
        i_clear = 1'b0; i_load = 1'b0;
        cmp("clr_ld_count", 32'(o_count), 32'd0);
        cmp("clr_ld_wrap", 32'(o_wrap), 32'd0);
        cmp("clr_ld_pend", 32'(o_k_pending), 32'd0);
        for (int j = 1; j <= 6; j++) begin
            tick();
            cmp("k6_count", 32'(o_count), 32'(j % 6));
            cmp("k6_wrap", 32'(o_wrap), 32'(j == 6));
        end

        // K = 0 means 256
        apply_k(8'd0);
        i_en = 1'b1;
        for (int j = 0; j < 255; j++) tick();
        cmp("k256_top", 32'(o_count), 32'd255);
        cmp("k256_top_wrap", 32'(o_wrap), 32'd0);
        tick();
        cmp("k256_wrap_count", 32'(o_count), 32'd0);
        cmp("k256_wrap", 32'(o_wrap), 32'd1);

        // K = 1: wrap every enabled cycle
        apply_k(8'd1);
        i_en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            cmp("k1_count", 32'(o_count), 32'd0);
            cmp("k1_wrap", 32'(o_wrap), 32'd1);
        end

`ifdef COUNTER_MOD_K_UPDOWN_EN
        // Down counting with K = 5
        apply_k(8'd5);
        i_dir = 1'b1; i_en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            cmp("down_count", 32'(o_count), 32'(down_exp[j]));
            cmp("down_wrap", 32'(o_wrap), 32'(down_exp[j] == 4));
        end
        i_dir = 1'b0;
`endif

        // Asynchronous reset mid-count
        apply_k(8'd10);
        i_en = 1'b1;
        for (int j = 0; j < 7; j++) tick();
        cmp("pre_rst_count", 32'(o_count), 32'd7);
        #2 i_reset = 1'b1;
        #1;
        cmp("arst_count", 32'(o_count), 32'd0);
        cmp("arst_wrap", 32'(o_wrap), 32'd0);
        cmp("arst_wraps", 32'(o_wraps), 32'd0);
        cmp("arst_pending", 32'(o_k_pending), 32'd0);
        #2 i_reset = 1'b0;

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            i_en       = ($urandom % 4) != 0;
            i_clear    = ($urandom % 40) == 0;
            i_load     = ($urandom % 20) == 0;
            i_load_val = N'($urandom % 256);
            i_k_wr     = ($urandom % 25) == 0;
            i_k        = (($urandom % 8) == 0) ? N'($urandom % 256) : N'($urandom_range(0, 12));
            if (($urandom % 50) == 0) i_dir = ~i_dir;
        end
        tick();
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
